// File: rtl/fake_psx_pad.sv
// Digital PSX controller responder: answers the console's poll on data/ack.
// Define PSX_PAD_ANALOG_EN to answer as an analog pad (ID 8'h73, four extra stick bytes).
module fake_psx_pad #(
    parameter logic [7:0] PAD_ID    = 8'h41,
    parameter int         ACK_DELAY = 4,
    parameter int         ACK_LEN   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        att,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic [15:0] buttons,
    input  logic [31:0] sticks,
    output logic        data,
    output logic        ack,
    output logic        busy,
    output logic        polled
);

    typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_PULSE, DONE} state_t;

`ifdef PSX_PAD_ANALOG_EN
    localparam logic [3:0] LAST    = 4'd8;
    localparam logic [7:0] ID_BYTE = 8'h73;
    logic [7:0]  unused_pad_id;
    logic [31:0] sticks_q;
    assign unused_pad_id = PAD_ID;
`else
    localparam logic [3:0] LAST    = 4'd4;
    localparam logic [7:0] ID_BYTE = PAD_ID;
    logic unused_sticks;
    assign unused_sticks = ^sticks;
`endif

    localparam logic [3:0] DELAY_END = 4'(ACK_DELAY - 1);
    localparam logic [3:0] LEN_END   = 4'(ACK_LEN - 1);

    logic   att_s1_q, att_s2_q, att_prev_q;
    logic   psx_s1_q, psx_s2_q, psx_prev_q;
    logic   cmd_s1_q, cmd_s2_q;
    logic   att_fall, att_rise, psx_fall, psx_rise;
    state_t state_q, state_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  cmd_sr_q, cmd_sr_d;
    logic [3:0]  delay_q, delay_d;
    logic        data_q, data_d, ack_q, ack_d, busy_q, busy_d, polled_q, polled_d;
    logic [15:0] btn_q;
    logic [7:0]  reply_byte, cmd_byte;

    assign att_fall = att_prev_q & ~att_s2_q;
    assign att_rise = ~att_prev_q & att_s2_q;
    assign psx_fall = psx_prev_q & ~psx_s2_q;
    assign psx_rise = ~psx_prev_q & psx_s2_q;
    assign cmd_byte = {cmd_s2_q, cmd_sr_q};

    always_comb begin
        reply_byte = 8'hFF;
        case (byte_idx_q)
            4'd0:    reply_byte = 8'hFF;
            4'd1:    reply_byte = ID_BYTE;
            4'd2:    reply_byte = 8'h5A;
            4'd3:    reply_byte = btn_q[7:0];
            4'd4:    reply_byte = btn_q[15:8];
`ifdef PSX_PAD_ANALOG_EN
            4'd5:    reply_byte = sticks_q[7:0];
            4'd6:    reply_byte = sticks_q[15:8];
            4'd7:    reply_byte = sticks_q[23:16];
            4'd8:    reply_byte = sticks_q[31:24];
`endif
            default: reply_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_sr_d   = cmd_sr_q;
        delay_d    = delay_q;
        data_d     = data_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        polled_d   = 1'b0;
        if (att_rise) begin
            state_d = IDLE;
            data_d  = 1'b1;
            ack_d   = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (att_fall) begin
                        state_d    = SHIFT;
                        byte_idx_d = 4'd0;
                        bit_cnt_d  = 3'd0;
                        busy_d     = 1'b1;
                        data_d     = 1'b1;
                        ack_d      = 1'b1;
                    end
                end
                SHIFT: begin
                    if (psx_fall) begin
                        data_d = reply_byte[bit_cnt_q];
                    end else if (psx_rise) begin
                        cmd_sr_d  = cmd_byte[7:1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // Only a "read buttons" request (01, 42) is answered past its header
                            if ((byte_idx_q == 4'd0 && cmd_byte != 8'h01) ||
                                (byte_idx_q == 4'd1 && cmd_byte != 8'h42)) begin
                                state_d = DONE;
                                data_d  = 1'b1;
                            end else if (byte_idx_q == LAST) begin
                                polled_d = 1'b1;
                                state_d  = DONE;
                                data_d   = 1'b1;
                            end else begin
                                byte_idx_d = byte_idx_q + 4'd1;
                                delay_d    = 4'd0;
                                state_d    = ACK_WAIT;
                            end
                        end
                    end
                end
                ACK_WAIT: begin
                    if (psx_fall) begin
                        ack_d   = 1'b1;
                        state_d = SHIFT;
                        data_d  = reply_byte[bit_cnt_q];
                    end else if (delay_q == DELAY_END) begin
                        ack_d   = 1'b0;
                        delay_d = 4'd0;
                        state_d = ACK_PULSE;
                    end else begin
                        delay_d = delay_q + 4'd1;
                    end
                end
                ACK_PULSE: begin
                    if (psx_fall) begin
                        ack_d   = 1'b1;
                        state_d = SHIFT;
                        data_d  = reply_byte[bit_cnt_q];
                    end else if (delay_q == LEN_END) begin
                        ack_d   = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        delay_d = delay_q + 4'd1;
                    end
                end
                DONE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // att synchronizer resets low so an att already low at release is not seen as a fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            att_s1_q   <= 1'b0;
            att_s2_q   <= 1'b0;
            att_prev_q <= 1'b0;
            psx_s1_q   <= 1'b1;
            psx_s2_q   <= 1'b1;
            psx_prev_q <= 1'b1;
            cmd_s1_q   <= 1'b1;
            cmd_s2_q   <= 1'b1;
            state_q    <= IDLE;
            byte_idx_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            cmd_sr_q   <= 7'd0;
            delay_q    <= 4'd0;
            data_q     <= 1'b1;
            ack_q      <= 1'b1;
            busy_q     <= 1'b0;
            polled_q   <= 1'b0;
        end else begin
            att_s1_q   <= att;
            att_s2_q   <= att_s1_q;
            att_prev_q <= att_s2_q;
            psx_s1_q   <= psx_clk;
            psx_s2_q   <= psx_s1_q;
            psx_prev_q <= psx_s2_q;
            cmd_s1_q   <= cmd;
            cmd_s2_q   <= cmd_s1_q;
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_sr_q   <= cmd_sr_d;
            delay_q    <= delay_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            polled_q   <= polled_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= 16'hFFFF;
`ifdef PSX_PAD_ANALOG_EN
            sticks_q <= 32'd0;
`endif
        end else if (att_fall) begin
            btn_q <= buttons;
`ifdef PSX_PAD_ANALOG_EN
            sticks_q <= sticks;
`endif
        end
    end

    assign data   = data_q;
    assign ack    = ack_q;
    assign busy   = busy_q;
    assign polled = polled_q;

endmodule

// File: tb/tb_fake_psx_pad.sv
// Self-checking bench for fake_psx_pad: table vectors, corner sequences and random polls
// checked against a byte-level reference model of the pad's reply.
module tb_fake_psx_pad;

    localparam int ACK_DELAY = 4;
    localparam int ACK_LEN   = 2;
    localparam int HALF      = 8;
    localparam int GAP       = 8;
`ifdef PSX_PAD_ANALOG_EN
    localparam int         TB_LAST = 8;
    localparam logic [7:0] TB_ID   = 8'h73;
`else
    localparam int         TB_LAST = 4;
    localparam logic [7:0] TB_ID   = 8'h41;
`endif

    typedef struct {
        logic [15:0] btn;
        logic [7:0]  c0;
        logic [7:0]  c1;
        logic [39:0] exp;
        int          acks;
        int          pol;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, att = 1'b1, psx_clk = 1'b1, cmd = 1'b1;
    logic [15:0] buttons = 16'hFFFF;
    logic [31:0] sticks = 32'h80807F7F;
    logic        data, ack, busy, polled;

    int   checks = 0, errors = 0;
    int   cyc = 0, last_rise_cyc = 0;
    int   ack_falls = 0, ack_timing_err = 0, polled_high = 0, ack_fall_cyc = 0;
    logic ack_prev = 1'b1;

    always #5 clk = ~clk;

    fake_psx_pad #(.PAD_ID(8'h41), .ACK_DELAY(ACK_DELAY), .ACK_LEN(ACK_LEN)) dut (
        .clk(clk), .rst(rst), .att(att), .psx_clk(psx_clk), .cmd(cmd),
        .buttons(buttons), .sticks(sticks),
        .data(data), .ack(ack), .busy(busy), .polled(polled)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // ack low must start 3 sync/register clocks plus ACK_DELAY after the raw rise
    always @(negedge clk) begin
        if (!rst) begin
            if (ack_prev && !ack) begin
                ack_falls = ack_falls + 1;
                ack_fall_cyc = cyc;
                if (cyc - last_rise_cyc != 3 + ACK_DELAY) ack_timing_err = ack_timing_err + 1;
            end
            if (!ack_prev && ack && (cyc - ack_fall_cyc != ACK_LEN))
                ack_timing_err = ack_timing_err + 1;
            if (polled) polled_high = polled_high + 1;
        end
        ack_prev = ack;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void refPoll(input logic [15:0] btn, input logic [31:0] stk,
                                    input logic [7:0] c0, input logic [7:0] c1,
                                    output logic [71:0] exp, output int acks, output int pol);
        logic [7:0] full [0:8];
        int stop;
        full[0] = 8'hFF;        full[1] = TB_ID;        full[2] = 8'h5A;
        full[3] = btn[7:0];     full[4] = btn[15:8];
        full[5] = stk[7:0];     full[6] = stk[15:8];
        full[7] = stk[23:16];   full[8] = stk[31:24];
        stop = TB_LAST;
        if (c0 != 8'h01) stop = 0;
        else if (c1 != 8'h42) stop = 1;
        for (int i = 0; i < 9; i++) exp[8*i +: 8] = (i <= stop) ? full[i] : 8'hFF;
        acks = stop;
        pol  = (stop == TB_LAST) ? 1 : 0;
    endfunction

    task automatic psxByte(input logic [7:0] c, input int nbits, output logic [7:0] got);
        got = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            psx_clk = 1'b0;
            cmd = c[i];
            repeat (HALF) @(negedge clk);
            got[i] = data;
            psx_clk = 1'b1;
            last_rise_cyc = cyc;
            repeat (HALF - 1) @(negedge clk);
        end
    endtask

    task automatic runPoll(input logic [15:0] btn, input logic [31:0] stk, input logic [71:0] cmds,
                           input bit mid_change, input logic [15:0] mid_btn,
                           output logic [71:0] got, output int acks, output int terr, output int pol,
                           output logic busy_during, output logic [2:0] end_state);
        int f0, t0, p0;
        logic [7:0] b;
        @(negedge clk);
        buttons = btn;
        sticks  = stk;
        f0 = ack_falls; t0 = ack_timing_err; p0 = polled_high;
        att = 1'b0;
        repeat (6) @(negedge clk);
        busy_during = busy;
        got = '1;
        for (int k = 0; k <= TB_LAST; k++) begin
            if (mid_change && k == 2) buttons = mid_btn;
            psxByte(cmds[8*k +: 8], 8, b);
            got[8*k +: 8] = b;
            repeat (GAP) @(negedge clk);
        end
        att = 1'b1;
        repeat (6) @(negedge clk);
        end_state = {busy, data, ack};
        acks = ack_falls - f0;
        terr = ack_timing_err - t0;
        pol  = polled_high - p0;
    endtask

    task automatic comparePoll(input string tag, input logic [71:0] got, input logic [71:0] exp,
                               input int acks, input int exp_acks, input int terr,
                               input int pol, input int exp_pol,
                               input logic busy_during, input logic [2:0] end_state);
        for (int k = 0; k <= TB_LAST; k++)
            checkOutput($sformatf("%s byte%0d", tag, k), 32'(got[8*k +: 8]), 32'(exp[8*k +: 8]));
        checkOutput({tag, " ack count"}, acks, exp_acks);
        checkOutput({tag, " ack timing"}, terr, 0);
        checkOutput({tag, " polled cycles"}, pol, exp_pol);
        checkOutput({tag, " busy during"}, 32'(busy_during), 1);
        checkOutput({tag, " busy/data/ack after"}, 32'(end_state), 32'b011);
    endtask

    task automatic fullCheck(input string tag, input logic [15:0] btn, input logic [31:0] stk,
                             input logic [71:0] cmds, input bit mid_change, input logic [15:0] mid_btn);
        logic [71:0] exp, got;
        int ea, ep, a, t, p;
        logic bd;
        logic [2:0] es;
        refPoll(btn, stk, cmds[7:0], cmds[15:8], exp, ea, ep);
        runPoll(btn, stk, cmds, mid_change, mid_btn, got, a, t, p, bd, es);
        comparePoll(tag, got, exp, a, ea, t, p, ep, bd, es);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [71:0] cmds, exp, got;
        int ma, mp, a, t, p;
        logic bd;
        logic [2:0] es;
        cmds = {8'($urandom), 32'($urandom), 32'($urandom)};
        cmds[7:0]  = v.c0;
        cmds[15:8] = v.c1;
        refPoll(v.btn, 32'h80807F7F, v.c0, v.c1, exp, ma, mp);
        exp[39:0] = v.exp;
        runPoll(v.btn, 32'h80807F7F, cmds, 1'b0, 16'h0, got, a, t, p, bd, es);
        comparePoll($sformatf("vec%0d", idx), got, exp, a, v.acks, t, p, v.pol, bd, es);
    endtask

    initial begin
        vec_t vecs [6];
        logic [7:0]  b;
        logic [71:0] cmds;
        logic [15:0] rbtn;
        bit seen;
        int f0;

        vecs[0] = '{16'hFFFE, 8'h01, 8'h42, {8'hFF, 8'hFE, 8'h5A, TB_ID, 8'hFF}, TB_LAST, 1};
        vecs[1] = '{16'h1234, 8'h01, 8'h42, {8'h12, 8'h34, 8'h5A, TB_ID, 8'hFF}, TB_LAST, 1};
        vecs[2] = '{16'h0000, 8'h03, 8'h42, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, 0};
        vecs[3] = '{16'hABCD, 8'h01, 8'h43, {8'hFF, 8'hFF, 8'hFF, TB_ID, 8'hFF}, 1, 0};
        vecs[4] = '{16'h0000, 8'h01, 8'h42, {8'h00, 8'h00, 8'h5A, TB_ID, 8'hFF}, TB_LAST, 1};
        vecs[5] = '{16'h5A5A, 8'h00, 8'h42, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, 0};

        repeat (3) @(negedge clk);
        checkOutput("reset data", 32'(data), 1);
        checkOutput("reset ack", 32'(ack), 1);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset polled", 32'(polled), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        // att raised part-way through byte 2
        @(negedge clk);
        buttons = 16'h1111;
        att = 1'b0;
        repeat (6) @(negedge clk);
        psxByte(8'h01, 8, b);
        repeat (GAP) @(negedge clk);
        psxByte(8'h42, 8, b);
        checkOutput("T3 byte1", 32'(b), 32'(TB_ID));
        repeat (GAP) @(negedge clk);
        psxByte(8'h00, 3, b);
        checkOutput("T3 partial bits", 32'(b[2:0]), 32'b010);
        checkOutput("T3 data before att", 32'(data), 0);
        @(negedge clk);
        att = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("T3 busy/data/ack", 32'({busy, data, ack}), 32'b011);
        repeat (3) @(negedge clk);
        fullCheck("T3 repoll", 16'h2468, 32'h01020304, {56'h0, 16'h4201}, 1'b0, 16'h0);

        // buttons change mid-poll must not disturb the snapshot
        fullCheck("T4 first", 16'hFFFF, 32'h11223344, {56'h0, 16'h4201}, 1'b1, 16'h0000);
        fullCheck("T4 second", 16'h0000, 32'h11223344, {56'h0, 16'h4201}, 1'b0, 16'h0);

        // reset pulsed while ack is low
        @(negedge clk);
        att = 1'b0;
        repeat (6) @(negedge clk);
        psxByte(8'h01, 8, b);
        seen = 1'b0;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            if (!ack) seen = 1'b1;
        end
        checkOutput("T5 ack asserted", 32'(seen), 1);
        rst = 1'b1;
        #1;
        checkOutput("T5 async ack", 32'(ack), 1);
        checkOutput("T5 async data", 32'(data), 1);
        checkOutput("T5 async busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        f0 = ack_falls;
        for (int k = 0; k < 2; k++) begin
            psxByte(8'h42, 8, b);
            checkOutput($sformatf("T5 data after release byte%0d", k), 32'(b), 32'hFF);
            repeat (GAP) @(negedge clk);
        end
        checkOutput("T5 acks after release", ack_falls - f0, 0);
        checkOutput("T5 busy after release", 32'(busy), 0);
        att = 1'b1;
        repeat (6) @(negedge clk);
        fullCheck("T5 repoll", 16'hBEEF, 32'h80807F7F, {56'h0, 16'h4201}, 1'b0, 16'h0);

        for (int r = 0; r < 8; r++) begin
            cmds = {8'($urandom), 32'($urandom), 32'($urandom)};
            cmds[7:0]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01;
            cmds[15:8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h42;
            rbtn = 16'($urandom);
            fullCheck($sformatf("rand%0d", r), rbtn, $urandom, cmds, 1'b0, 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
